// File: rtl/i2c_eeprom_master_if.sv
// Bundle of the Wishbone slave port and the byte-controller command port
// of i2c_eeprom_master.
//   slave  : view used by the bridge (Wishbone slave, byte-controller driver)
//   master : view used by the environment (Wishbone master + byte controller)
interface i2c_eeprom_master_if;
  // Wishbone side
  logic [7:0] wb_adr_i;
  logic [7:0] wb_dat_i;
  logic       wb_we_i;
  logic       wb_cyc_i;
  logic       wb_stb_i;
  logic [7:0] wb_dat_o;
  logic       wb_ack_o;
  logic       wb_err_o;
  // Byte-controller command side
  logic       bc_start;
  logic       bc_stop;
  logic       bc_read;
  logic       bc_write;
  logic       bc_ack_in;
  logic [7:0] bc_din;
  logic       bc_cmd_ack;
  logic       bc_ack_out;
  logic [7:0] bc_dout;
  logic       bc_al;

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
    input  bc_cmd_ack, bc_ack_out, bc_dout, bc_al,
    output wb_dat_o, wb_ack_o, wb_err_o,
    output bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din
  );

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_cyc_i, wb_stb_i,
    output bc_cmd_ack, bc_ack_out, bc_dout, bc_al,
    input  wb_dat_o, wb_ack_o, wb_err_o,
    input  bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din
  );
endinterface

// File: rtl/i2c_eeprom_master.sv
// Wishbone-slave to I2C-master bridge for an EEPROM-style memory.
// Turns single 8-bit Wishbone reads/writes into I2C byte-write and
// random-read (repeated START) sequences on an i2c_master_byte_ctrl.
// Ports:
//   clk_i - system clock
//   rst_i - synchronous active-high reset
//   bus   - Wishbone slave signals and byte-controller command signals
module i2c_eeprom_master #(
  parameter logic [6:0]  DEV_ADDR  = 7'h50,
  parameter int unsigned TIMEOUT_W = 16
) (
  input logic                clk_i,
  input logic                rst_i,
  i2c_eeprom_master_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, DEVW, MADR, DATW, RSTRT, RDAT, STOPERR, DONE
  } state_t;

  typedef struct packed {
    logic       start;
    logic       stop;
    logic       read;
    logic       write;
    logic       ack_in;
    logic [7:0] din;
  } cmd_t;

  localparam cmd_t CMD_NONE = '0;
  // Value one below all-ones: the increment that would reach all-ones fires the timeout.
  localparam logic [TIMEOUT_W-1:0] WDOG_LAST = ~(TIMEOUT_W'(1));

  state_t               state;
  cmd_t                 cmd_q;
  logic                 cmd_active;
  logic [TIMEOUT_W-1:0] wdog;
  logic [7:0]           adr_q;
  logic [7:0]           dat_q;
  logic                 we_q;
  logic                 dropped;
  logic                 ack_q;
  logic                 err_q;
  logic [7:0]           rdat_q;
  logic                 respond_c;

  // Command word issued in each command state.
  function automatic cmd_t cmd_for(input state_t s, input logic [7:0] adr, input logic [7:0] dat);
    cmd_t c;
    c = CMD_NONE;
    case (s)
      DEVW:    begin c.start = 1'b1; c.write = 1'b1; c.din = {DEV_ADDR, 1'b0}; end
      MADR:    begin c.write = 1'b1; c.din = adr; end
      DATW:    begin c.write = 1'b1; c.stop = 1'b1; c.din = dat; end
      RSTRT:   begin c.start = 1'b1; c.write = 1'b1; c.din = {DEV_ADDR, 1'b1}; end
      RDAT:    begin c.read = 1'b1; c.stop = 1'b1; c.ack_in = 1'b1; end
      STOPERR: begin c.stop = 1'b1; end
      default: c = CMD_NONE;
    endcase
    return c;
  endfunction

  // Ack/err only goes back to a master that is still in the same cycle.
  assign respond_c = bus.wb_cyc_i & bus.wb_stb_i & ~dropped;

  // Transaction sequencer. Commands are held until cmd_ack; a command state
  // entered via cmd_ack first spends one cycle with all command bits low.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      cmd_q      <= CMD_NONE;
      cmd_active <= 1'b0;
      wdog       <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      we_q       <= 1'b0;
      dropped    <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      rdat_q     <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      if (!bus.wb_cyc_i) dropped <= 1'b1;

      unique case (state)
        IDLE: begin
          if (bus.wb_cyc_i && bus.wb_stb_i) begin
            adr_q      <= bus.wb_adr_i;
            dat_q      <= bus.wb_dat_i;
            we_q       <= bus.wb_we_i;
            dropped    <= 1'b0;
            state      <= DEVW;
            cmd_q      <= cmd_for(DEVW, bus.wb_adr_i, bus.wb_dat_i);
            cmd_active <= 1'b1;
            wdog       <= '0;
          end
        end

        DONE: state <= IDLE;

        default: begin
          if (bus.bc_al) begin
            // Lost the bus: drop everything, no STOP.
            cmd_q      <= CMD_NONE;
            cmd_active <= 1'b0;
            state      <= DONE;
            err_q      <= respond_c;
          end else if (!cmd_active) begin
            cmd_q      <= cmd_for(state, adr_q, dat_q);
            cmd_active <= 1'b1;
          end else if (bus.bc_cmd_ack) begin
            cmd_q      <= CMD_NONE;
            cmd_active <= 1'b0;
            wdog       <= '0;
            case (state)
              DEVW:  state <= bus.bc_ack_out ? STOPERR : MADR;
              MADR:  state <= bus.bc_ack_out ? STOPERR : (we_q ? DATW : RSTRT);
              RSTRT: state <= bus.bc_ack_out ? STOPERR : RDAT;
              DATW: begin
                state <= DONE;
                ack_q <= respond_c & ~bus.bc_ack_out;
                err_q <= respond_c & bus.bc_ack_out;
              end
              RDAT: begin
                rdat_q <= bus.bc_dout;
                state  <= DONE;
                ack_q  <= respond_c;
              end
              STOPERR: begin
                state <= DONE;
                err_q <= respond_c;
              end
              default: state <= IDLE;
            endcase
          end else if (wdog == WDOG_LAST) begin
            cmd_q      <= CMD_NONE;
            cmd_active <= 1'b0;
            state      <= DONE;
            err_q      <= respond_c;
          end else begin
            wdog <= wdog + TIMEOUT_W'(1);
          end
        end
      endcase
    end
  end

  assign bus.wb_dat_o  = rdat_q;
  assign bus.wb_ack_o  = ack_q;
  assign bus.wb_err_o  = err_q;
  assign bus.bc_start  = cmd_q.start;
  assign bus.bc_stop   = cmd_q.stop;
  assign bus.bc_read   = cmd_q.read;
  assign bus.bc_write  = cmd_q.write;
  assign bus.bc_ack_in = cmd_q.ack_in;
  assign bus.bc_din    = cmd_q.din;

endmodule

// File: tb/tb_i2c_eeprom_master.sv
// Testbench for i2c_eeprom_master: Wishbone-level transactions against a
// behavioural byte-controller/EEPROM responder, with expected command
// sequences and results derived from the transaction description.
module tb_i2c_eeprom_master;
  localparam int unsigned TW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_eeprom_master_if bus();

  i2c_eeprom_master #(.DEV_ADDR(7'h50), .TIMEOUT_W(TW)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  int unsigned cyc_n    = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  // Responder knobs (written by the stimulus only)
  int nack_idx = -1;
  int al_idx   = -1;
  int hang_idx = -1;
  int lat_max  = 4;
  int txn_id   = 0;

  // Responder-owned state
  logic [12:0] log_q[$];     // {start,stop,read,write,ack_in,din}
  int          last_ack_cyc = 0;
  int          rule_viol    = 0;
  logic [7:0]  slave_mem[256];
  logic [7:0]  ref_mem[256];
  logic [7:0]  last_rd = 8'h00;

  // Byte controller + EEPROM behaviour, driven at the falling edge.
  initial for (int i = 0; i < 256; i++) slave_mem[i] = 8'(i * 7 + 3);
  always @(negedge clk) begin
    logic [12:0] c;
    logic        nk;
    static logic [12:0] prev_cmd = '0;
    static logic        prev_ack = 1'b0;
    static bit          active   = 1'b0;
    static int          cnt      = 0;
    static int          lat      = 1;
    static int          cmd_idx  = 0;
    static int          seen_txn = 0;
    static int          byte_n   = 0;
    static logic [7:0]  ptr      = 8'h00;
    c = {bus.bc_start, bus.bc_stop, bus.bc_read, bus.bc_write, bus.bc_ack_in, bus.bc_din};
    if (seen_txn != txn_id) begin seen_txn = txn_id; cmd_idx = 0; end
    if (prev_ack && c != '0) rule_viol++;
    if (prev_cmd != '0 && !prev_ack && c != '0 && c != prev_cmd) rule_viol++;
    bus.bc_cmd_ack = 1'b0;
    bus.bc_al      = 1'b0;
    bus.bc_ack_out = 1'b0;
    bus.bc_dout    = 8'($urandom);
    prev_ack = 1'b0;
    if (c == '0) begin
      active = 1'b0;
    end else if (!active) begin
      active = 1'b1;
      cnt    = 0;
      lat    = int'($urandom_range(1, lat_max));
      log_q.push_back(c);
    end else begin
      cnt++;
      if (cnt >= lat && cmd_idx != hang_idx) begin
        nk = (cmd_idx == nack_idx) || (c[12] && c[7:1] != 7'h50);
        bus.bc_cmd_ack = 1'b1;
        bus.bc_ack_out = nk;
        if (cmd_idx == al_idx) bus.bc_al = 1'b1;
        if (c[12] && c[9]) byte_n = 0;
        else if (c[9]) begin
          if (byte_n == 0) ptr = c[7:0];
          else if (!nk && cmd_idx != al_idx) begin slave_mem[ptr] = c[7:0]; ptr++; end
          byte_n++;
        end
        if (c[10]) bus.bc_dout = slave_mem[ptr];
        last_ack_cyc = int'(cyc_n);
        prev_ack = 1'b1;
        active   = 1'b0;
        cmd_idx++;
      end
    end
    prev_cmd = c;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int last_busy = 0;

  // One Wishbone transaction plus all checks against the expected outcome.
  task automatic txn(input string tag, input logic we, input logic [7:0] adr, input logic [7:0] dat,
                     input int nk, input int al, input int hang, input bit drop);
    logic [12:0] full[4];
    logic [12:0] exp_q[$];
    logic [7:0]  pdat, exp_dat;
    int          n, last, base, n_ack, n_err, busy, first_i, pulse_cyc, nlog;
    bit          ok;

    // Expected I2C command list and outcome
    full[0] = {5'b10010, 8'hA0};
    full[1] = {5'b00010, adr};
    full[2] = we ? {5'b01010, dat} : {5'b10010, 8'hA1};
    full[3] = {5'b01101, 8'h00};
    n = we ? 3 : 4;
    ok = 1'b1;
    last = n - 1;
    if (al >= 0) begin last = al; ok = 1'b0; end
    else if (nk >= 0) begin last = nk; ok = 1'b0; end
    else if (hang >= 0) begin last = hang; ok = 1'b0; end
    for (int k = 0; k <= last; k++) exp_q.push_back(full[k]);
    if (al < 0 && nk >= 0 && nk < n - 1) exp_q.push_back({5'b01000, 8'h00});
    exp_dat = (!we && ok) ? ref_mem[adr] : last_rd;

    nack_idx = nk; al_idx = al; hang_idx = hang;
    @(negedge clk);
    txn_id++;
    base = log_q.size();
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    bus.wb_we_i = we; bus.wb_adr_i = adr; bus.wb_dat_i = dat;
    n_ack = 0; n_err = 0; busy = 0; first_i = -1; pulse_cyc = -1; pdat = '0;
    for (int i = 0; i < (drop ? 80 : 300); i++) begin
      @(negedge clk);
      if (drop && i == 2) begin bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; end
      if (bus.bc_start || bus.bc_stop || bus.bc_read || bus.bc_write) begin
        busy++;
        if (first_i < 0) first_i = i;
      end
      if (bus.wb_ack_o || bus.wb_err_o) begin
        n_ack += int'(bus.wb_ack_o);
        n_err += int'(bus.wb_err_o);
        pulse_cyc = int'(cyc_n);
        pdat = bus.wb_dat_o;
        if (!drop) break;
      end
    end
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    @(negedge clk);
    n_ack += int'(bus.wb_ack_o);
    n_err += int'(bus.wb_err_o);
    last_busy = busy;

    if (drop) begin
      check($sformatf("%s ack_count", tag), 32'(n_ack), 32'(0));
      check($sformatf("%s err_count", tag), 32'(n_err), 32'(0));
    end else begin
      check($sformatf("%s ack_count", tag), 32'(n_ack), 32'(ok ? 1 : 0));
      check($sformatf("%s err_count", tag), 32'(n_err), 32'(ok ? 0 : 1));
      check($sformatf("%s dat_o", tag), 32'(pdat), 32'(exp_dat));
      if (hang < 0)
        check($sformatf("%s pulse_latency", tag), 32'(pulse_cyc - last_ack_cyc), 32'(1));
    end
    check($sformatf("%s req_latency", tag), 32'(first_i), 32'(0));
    nlog = log_q.size() - base;
    check($sformatf("%s cmd_count", tag), 32'(nlog), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < nlog; k++)
      check($sformatf("%s cmd%0d", tag, k), 32'(log_q[base + k]), 32'(exp_q[k]));

    if (we && ok) ref_mem[adr] = dat;
    if (!we && ok) last_rd = ref_mem[adr];
  endtask

  initial begin
    bit found;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);
    bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0; bus.wb_we_i = 1'b0;
    bus.wb_adr_i = 8'h00; bus.wb_dat_i = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          32'({bus.wb_ack_o, bus.wb_err_o, bus.wb_dat_o, bus.bc_start, bus.bc_stop,
               bus.bc_read, bus.bc_write, bus.bc_ack_in, bus.bc_din}), 32'(0));
    rst = 1'b0;
    lat_max = 4;

    txn("write_3c", 1'b1, 8'h3C, 8'hA5, -1, -1, -1, 1'b0);
    txn("read_3c", 1'b0, 8'h3C, 8'h00, -1, -1, -1, 1'b0);
    check("read_3c value", 32'(last_rd), 32'(8'hA5));
    txn("dev_nack", 1'b1, 8'h10, 8'h11, 0, -1, -1, 1'b0);
    txn("al_madr", 1'b0, 8'h3C, 8'h00, -1, 1, -1, 1'b0);
    txn("timeout", 1'b1, 8'h20, 8'h77, -1, -1, 0, 1'b0);
    check("timeout busy_cycles", 32'(last_busy), 32'(15));
    txn("write_after_tmo", 1'b1, 8'h20, 8'h77, -1, -1, -1, 1'b0);
    txn("withdraw", 1'b1, 8'h21, 8'h99, -1, -1, -1, 1'b1);
    txn("read_withdrawn", 1'b0, 8'h21, 8'h00, -1, -1, -1, 1'b0);

    // Reset while the final read command is outstanding
    nack_idx = -1; al_idx = -1; hang_idx = 3;
    @(negedge clk);
    txn_id++;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1; bus.wb_we_i = 1'b0; bus.wb_adr_i = 8'h3C;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.bc_read) begin found = 1'b1; break; end
    end
    check("reset_mid_rdat reached", 32'(found), 32'(1));
    rst = 1'b1; bus.wb_cyc_i = 1'b0; bus.wb_stb_i = 1'b0;
    @(negedge clk);
    check("reset_mid_rdat outputs",
          32'({bus.wb_ack_o, bus.wb_err_o, bus.wb_dat_o, bus.bc_start, bus.bc_stop,
               bus.bc_read, bus.bc_write, bus.bc_ack_in, bus.bc_din}), 32'(0));
    rst = 1'b0;
    last_rd = 8'h00;
    hang_idx = -1;
    txn("read_after_rst", 1'b0, 8'h3C, 8'h00, -1, -1, -1, 1'b0);

    // Randomized traffic with occasional NACKs and arbitration loss
    for (int t = 0; t < 40; t++) begin
      logic       rwe;
      logic [7:0] ra, rd;
      int         kind, nk, al, n;
      rwe  = 1'($urandom_range(0, 1));
      ra   = 8'h40 + 8'($urandom_range(0, 7));
      rd   = 8'($urandom);
      kind = int'($urandom_range(0, 5));
      n    = rwe ? 3 : 4;
      nk   = -1;
      al   = -1;
      if (kind == 3) nk = int'($urandom_range(0, 2));
      if (kind == 4) al = int'($urandom_range(0, n - 1));
      lat_max = int'($urandom_range(1, 6));
      txn($sformatf("rnd%0d", t), rwe, ra, rd, nk, al, -1, 1'b0);
    end

    check("command_rule_violations", 32'(rule_viol), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation still running at %0t, limit 5000000", $time);
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/i2c_eeprom_master.md
Name: i2c_eeprom_master

Overview:
- Wishbone-slave to I2C-master bridge; the initiator for the team's I2C slave memory (device address 7'h50, 8-bit word address, 8-bit data).
- Converts single 8-bit Wishbone reads and writes into EEPROM-style I2C transactions: byte write, and random read with a repeated START.
- Drives the command interface of an i2c_master_byte_ctrl instance in master mode. The byte controller owns SCL/SDA.

Parameters:
- DEV_ADDR, 7'h50, 7-bit I2C device address of the target memory.
- TIMEOUT_W, 16, width of the per-command cmd_ack watchdog counter. Timeout fires at 2**TIMEOUT_W-1 cycles.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous, active-high reset.
- wb_adr_i  in  8  memory word address.
- wb_dat_i  in  8  write data.
- wb_we_i  in  1  1 = write, 0 = read.
- wb_cyc_i  in  1  Wishbone cycle.
- wb_stb_i  in  1  Wishbone strobe.
- wb_dat_o  out  8  read data. Valid while wb_ack_o=1.
- wb_ack_o  out  1  one-cycle success acknowledge.
- wb_err_o  out  1  one-cycle error acknowledge (NACK, arbitration loss or timeout).
- bc_start  out  1  byte controller: generate START / repeated START.
- bc_stop  out  1  byte controller: generate STOP.
- bc_read  out  1  byte controller: read a byte.
- bc_write  out  1  byte controller: write bc_din.
- bc_ack_in  out  1  ACK bit the master sends after a read (1 = NACK).
- bc_din  out  8  byte to transmit.
- bc_cmd_ack  in  1  one-cycle pulse: current command complete.
- bc_ack_out  in  1  ACK bit received from the slave (0 = ACK).
- bc_dout  in  8  received byte. Valid with bc_cmd_ack.
- bc_al  in  1  arbitration lost.

Behaviour:
- Reset:
  - Applied only at a clk_i edge with rst_i=1.
  - All outputs go to 0 and the state goes to IDLE.
  - Reset mid-transaction abandons the bus with no STOP issued. Recovery is the byte controller's responsibility.
- Command rule:
  - In each command state, the bc_* command bits are held constant until bc_cmd_ack=1.
  - On the cycle after bc_cmd_ack, the command bits are all 0 for at least one cycle before the next command is asserted.
- States and transitions:
  - IDLE: accept a request when wb_cyc_i & wb_stb_i. Latch adr, dat and we. Go to DEVW.
  - DEVW: start=1, write=1, din={DEV_ADDR,1'b0}. On cmd_ack: if ack_out=0 go to MADR, else go to STOPERR.
  - MADR: write=1, din=latched adr. On cmd_ack with ACK: go to DATW if we=1, else go to RSTRT. On NACK: go to STOPERR.
  - DATW: write=1, stop=1, din=latched dat. On cmd_ack: go to DONE with ok = ~ack_out.
  - RSTRT: start=1, write=1, din={DEV_ADDR,1'b1}. On cmd_ack with ACK: go to RDAT. On NACK: go to STOPERR.
  - RDAT: read=1, stop=1, ack_in=1 (NACK the final byte). On cmd_ack: capture bc_dout into the read register. Go to DONE with ok=1.
  - STOPERR: stop=1 only. On cmd_ack: go to DONE with ok=0.
  - DONE: pulse wb_ack_o if ok, else wb_err_o, for exactly one cycle. The pulse is gated by wb_cyc_i & wb_stb_i. Then return to IDLE.
- Master withdraws mid-transaction: if wb_cyc_i falls, the I2C transaction still completes, but no ack/err is issued.
- New requests are accepted only in IDLE. A strobe held through DONE does not re-trigger in the same cycle; the next request is accepted on the cycle after return to IDLE.
- bc_al=1 in any non-IDLE state:
  - Immediately clear all command bits.
  - Go to DONE with ok=0. No STOP is issued.
  - bc_al takes priority over a simultaneous bc_cmd_ack.
- Watchdog:
  - Counter clears on every state entry and increments each cycle while waiting for cmd_ack.
  - On reaching all-ones: clear commands, go to DONE with ok=0.
  - Not active in IDLE or DONE.
- wb_dat_o:
  - Holds the last read byte.
  - Is meaningful only in the wb_ack_o cycle of a read; otherwise it is don't-care but stable.
  - Writes and errors leave it unchanged.
- Latency:
  - Wishbone side: 1 cycle from request to DEVW command assertion.
  - I2C side: 1 cycle from the final bc_cmd_ack to the ack/err pulse.

Test Plan:
- Write adr 8'h3C, dat 8'hA5, slave ACKs everything:
  - bc_din sequence is 8'hA0, 8'h3C, 8'hA5.
  - start only on the first command; stop only on the last.
  - wb_ack_o pulses once, one cycle after the third cmd_ack.
- Read adr 8'h3C, slave returns 8'hA5:
  - Commands are 8'hA0(start), 8'h3C, 8'hA1(start), then read with stop and ack_in=1.
  - wb_dat_o=8'hA5 with wb_ack_o=1.
- Device NACK on the first byte (ack_out=1):
  - Next command is stop-only.
  - After its cmd_ack, wb_err_o pulses once and wb_ack_o stays 0.
- bc_al asserted during MADR, together with cmd_ack:
  - All bc_* outputs are 0 the next cycle and no STOP is issued.
  - wb_err_o pulses, and the block returns to IDLE.
- TIMEOUT_W=4, cmd_ack never arrives:
  - Commands drop after 15 waiting cycles.
  - wb_err_o pulses, then a new write completes normally.
- Reset mid-RDAT with rst_i=1 for one cycle:
  - All outputs are 0 the next cycle.
  - A subsequent read succeeds with correct data.
